// File: rtl/tcp_flowid_manager_if.sv
// Flow ID allocator handshake bundle: allocation port, free port and status.
// The manager uses the slave modport; the new-flow/teardown side uses master.
interface tcp_flowid_manager_if #(
    parameter int unsigned FLOWID_W = 3
);
    logic                init_done;
    logic                flowid_avail;
    logic [FLOWID_W-1:0] flowid_alloc_id;
    logic                flowid_alloc_req;
    logic                flowid_free_val;
    logic [FLOWID_W-1:0] flowid_free_id;
    logic                flowid_free_rdy;
    logic [FLOWID_W:0]   flowid_free_cnt;
    logic                flowid_err;

    modport slave (
        output init_done,
        output flowid_avail,
        output flowid_alloc_id,
        input  flowid_alloc_req,
        input  flowid_free_val,
        input  flowid_free_id,
        output flowid_free_rdy,
        output flowid_free_cnt,
        output flowid_err
    );

    modport master (
        input  init_done,
        input  flowid_avail,
        input  flowid_alloc_id,
        output flowid_alloc_req,
        output flowid_free_val,
        output flowid_free_id,
        input  flowid_free_rdy,
        input  flowid_free_cnt,
        input  flowid_err
    );
endinterface

// File: rtl/tcp_flowid_manager.sv
// Circular free-list allocator for TCP flow IDs.
// After rst the list self-initialises with IDs 0..NUM_FLOWS-1 (one per cycle),
// then IDs are handed out in FIFO order and returned IDs are appended at the tail.
// Optional feature macro: TCP_FLOWID_DOUBLE_FREE_CHECK_EN tracks IDs in use and
// drops (and flags) frees of IDs that are not currently allocated.
module tcp_flowid_manager #(
    parameter int unsigned FLOWID_W  = 3,
    parameter int unsigned NUM_FLOWS = 2 ** FLOWID_W
) (
    input logic                 clk,
    input logic                 rst,
    tcp_flowid_manager_if.slave fif
);

    localparam int unsigned         LAST     = NUM_FLOWS - 1;
    localparam logic [FLOWID_W-1:0] LAST_IDX = LAST[FLOWID_W-1:0];
    localparam logic [FLOWID_W:0]   FULL_CNT = NUM_FLOWS[FLOWID_W:0];

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    state_e              state_q, state_d;
    logic [FLOWID_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FLOWID_W-1:0] head_q, head_d;
    logic [FLOWID_W-1:0] tail_q, tail_d;
    logic [FLOWID_W:0]   count_q, count_d;
    logic                err_q, err_d;

    logic [FLOWID_W-1:0] entry_q [NUM_FLOWS];
    logic                ent_we;
    logic [FLOWID_W-1:0] ent_waddr;
    logic [FLOWID_W-1:0] ent_wdata;

    logic                run;
    logic                alloc_ok;
    logic                free_ok;

`ifdef TCP_FLOWID_DOUBLE_FREE_CHECK_EN
    logic [NUM_FLOWS-1:0] in_use_q, in_use_d;
`endif

    // Pointer increment with wrap at NUM_FLOWS (which may be below 2**FLOWID_W).
    function automatic logic [FLOWID_W-1:0] ptr_inc(input logic [FLOWID_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + FLOWID_W'(1);
    endfunction

    assign run = (state_q == StRun);

    // Outputs come only from flops or a combinational read of the entry array.
    assign fif.init_done       = run;
    assign fif.flowid_avail    = run && (count_q != '0);
    assign fif.flowid_alloc_id = run ? entry_q[head_q] : '0;
    assign fif.flowid_free_rdy = run;
    assign fif.flowid_free_cnt = count_q;
    assign fif.flowid_err      = err_q;

    // Next-state: init sweep, alloc/free handshakes, error detection.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        err_d     = err_q;
        ent_we    = 1'b0;
        ent_waddr = wr_ptr_q;
        ent_wdata = wr_ptr_q;
        alloc_ok  = 1'b0;
        free_ok   = 1'b0;
`ifdef TCP_FLOWID_DOUBLE_FREE_CHECK_EN
        in_use_d  = in_use_q;
`endif

        // Requesting an ID that is not on offer is a protocol error in any state.
        if (fif.flowid_alloc_req && !fif.flowid_avail) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StInit: begin
                ent_we    = 1'b1;
                ent_waddr = wr_ptr_q;
                ent_wdata = wr_ptr_q;
                if (wr_ptr_q == LAST_IDX) begin
                    state_d = StRun;
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = FULL_CNT;
                end else begin
                    wr_ptr_d = wr_ptr_q + FLOWID_W'(1);
                end
            end

            StRun: begin
                alloc_ok = fif.flowid_avail && fif.flowid_alloc_req;

                if (fif.flowid_free_val) begin
                    // Overflow is judged on the pre-cycle count, before any same-cycle alloc.
                    free_ok = (count_q != FULL_CNT);
`ifdef TCP_FLOWID_DOUBLE_FREE_CHECK_EN
                    if (!in_use_q[fif.flowid_free_id]) begin
                        free_ok = 1'b0;
                    end
`endif
                    if (!free_ok) begin
                        err_d = 1'b1;
                    end
                end

                if (alloc_ok) begin
                    head_d = ptr_inc(head_q);
                end

                if (free_ok) begin
                    ent_we    = 1'b1;
                    ent_waddr = tail_q;
                    ent_wdata = fif.flowid_free_id;
                    tail_d    = ptr_inc(tail_q);
                end

                if (alloc_ok && !free_ok) begin
                    count_d = count_q - 1'b1;
                end else if (free_ok && !alloc_ok) begin
                    count_d = count_q + 1'b1;
                end

`ifdef TCP_FLOWID_DOUBLE_FREE_CHECK_EN
                if (free_ok) begin
                    in_use_d[fif.flowid_free_id] = 1'b0;
                end
                if (alloc_ok) begin
                    in_use_d[fif.flowid_alloc_id] = 1'b1;
                end
`endif
            end

            default: state_d = StInit;
        endcase
    end

    // Control state register with synchronous reset back to the init sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StInit;
            wr_ptr_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
`ifdef TCP_FLOWID_DOUBLE_FREE_CHECK_EN
            in_use_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            err_q    <= err_d;
`ifdef TCP_FLOWID_DOUBLE_FREE_CHECK_EN
            in_use_q <= in_use_d;
`endif
        end
    end

    // Free-list storage; contents are rebuilt by the init sweep so no reset is needed.
    always_ff @(posedge clk) begin
        if (ent_we) begin
            entry_q[ent_waddr] <= ent_wdata;
        end
    end

endmodule

// File: doc/tcp_flowid_manager.md
# tcp_flowid_manager

Free-list allocator for TCP flow IDs in the slow path. It sits beside the new-flow controller: it hands out a flow ID when the controller accepts a SYN, and it takes IDs back when the close/teardown logic retires a flow. After reset it self-initialises a circular free list with every ID, then serves allocations in FIFO order.

## Interface
Parameters:
- FLOWID_W, 3 — flow ID width.
- NUM_FLOWS, 2**FLOWID_W — number of IDs managed. Must be a power of two of at most 2**FLOWID_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- init_done  out  1  free list initialised; stays high until the next rst
- flowid_avail  out  1  an ID can be allocated this cycle
- flowid_alloc_id  out  FLOWID_W  ID at the list head; valid when flowid_avail=1
- flowid_alloc_req  in  1  consume the head ID; legal only when flowid_avail=1
- flowid_free_val  in  1  return an ID
- flowid_free_id  in  FLOWID_W  ID being returned
- flowid_free_rdy  out  1  free port ready; equals init_done
- flowid_free_cnt  out  FLOWID_W+1  number of IDs currently in the free list
- flowid_err  out  1  sticky error flag; cleared only by rst

## Operation
Storage and pointers:
- Storage is a NUM_FLOWS-entry flop array.
- head_ptr and tail_ptr are FLOWID_W bits wide and wrap modulo NUM_FLOWS.
- count is FLOWID_W+1 bits wide.

States:
- INIT: write_ptr steps 0..NUM_FLOWS-1, writing entry[i]=i, one entry per cycle.
  - After the last write: head_ptr=0, tail_ptr=0, count=NUM_FLOWS, go to RUN.
- RUN: init_done=1.
  - flowid_avail = (count!=0).
  - flowid_alloc_id = entry[head_ptr], read combinationally.

Handshakes in RUN:
- Allocation: flowid_avail && flowid_alloc_req → head_ptr+1, count-1.
- Free: flowid_free_val && flowid_free_rdy → entry[tail_ptr]=flowid_free_id, tail_ptr+1, count+1.

Boundary conditions:
- Alloc and free in the same cycle: both are performed and count is unchanged.
  - If the list was empty, the alloc is not legal (avail=0). The free still completes.
- Free while count==NUM_FLOWS (overflow): the free is dropped, no pointer moves, flowid_err sets.
- flowid_alloc_req while flowid_avail=0: ignored, and flowid_err sets.
- flowid_free_val during INIT: ignored (flowid_free_rdy=0). The producer must hold the request.
- rst in any state: returns to INIT at write_ptr=0. Any in-flight request is lost.

Reset values of outputs:
- init_done=0, flowid_avail=0, flowid_free_rdy=0.
- flowid_free_cnt=0 (stays 0 throughout INIT).
- flowid_alloc_id=0 (don't-care while avail=0).
- flowid_err=0.

## Timing
- Initialisation: the first cycle with rst low is INIT write 0. Writes complete at cycle NUM_FLOWS-1. In cycle NUM_FLOWS, init_done=flowid_avail=1, flowid_alloc_id=0 and flowid_free_cnt=NUM_FLOWS.
- Allocation takes effect in the accepting cycle. The next head ID is presented the following cycle, so back-to-back allocations run at 1 per cycle.
- Free-to-allocate latency is 1 cycle: an ID freed in cycle t into an empty list gives avail=1 with that ID in cycle t+1.
- All outputs are driven from flops or from a combinational read of flops. There is no comb path from flowid_alloc_req or flowid_free_val to any output.

## Configuration
- TCP_FLOWID_DOUBLE_FREE_CHECK_EN defined:
  - Keep an in_use[NUM_FLOWS] bitvector. It is all zero on reset and through INIT.
  - An accepted allocation sets in_use[id].
  - A free of an ID with in_use[id]=0 is dropped (no pointer or count change) and sets flowid_err.
  - A valid free clears in_use[id].
- TCP_FLOWID_DOUBLE_FREE_CHECK_EN undefined:
  - No in_use tracking.
  - Any free with count<NUM_FLOWS is accepted.
  - flowid_err sets only on overflow or an illegal alloc.

## Test plan (NUM_FLOWS=8)
- Reset, then idle → init_done rises exactly 8 cycles after rst falls; flowid_free_cnt=8, flowid_alloc_id=0.
- 8 consecutive alloc_req → IDs 0..7 one per cycle; then avail=0, cnt=0. A 9th req sets flowid_err.
- With the list empty, free ID 5 → next cycle avail=1, alloc_id=5, cnt=1.
- Hold 4 allocated IDs, then alloc and free(2) in the same cycle for 20 cycles → cnt constant at 4. Pointers wrap and IDs stay unique.
- Free ID 3 twice while it is allocated → with the macro, the second free is dropped, err=1, cnt+1 only. Without the macro, cnt+2.
- Assert rst mid-run with cnt=2 → back to INIT; after 8 cycles cnt=8 and allocation restarts at ID 0.
